imem_loader: RTL and testbench

Boot-time program loader that sits between a byte-stream source (UART/SPI receiver) and the write port of the byte-banked instruction memory. It accepts a length-prefixed load request and a stream of bytes over a valid/ready handshake. It packs the bytes little-endian into 32-bit words and issues one masked word write per word. A running byte checksum and done/error pulses let the boot controller release the core once the program image is resident.

---
 rtl/imem_loader.sv | 80 ++++++++
 tb/tb_imem_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a length-prefixed byte stream into masked little-endian word writes
module imem_loader #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [DMEM_ADDR_WIDTH:0]   i_len,
  input  logic                       i_rx_valid,
  input  logic [7:0]                 i_rx_data,
  output logic                       o_rx_ready,
  output logic [DMEM_ADDR_WIDTH-1:0] o_addr,
  output logic                       o_we,
  output logic [3:0]                 o_size,
  output logic [31:0]                o_din,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  output logic [31:0]                o_sum
);
  localparam int W = DMEM_ADDR_WIDTH;
  localparam logic [W:0] CAP = {1'b1, {W{1'b0}}};
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [W:0] len, cnt;
  logic [3:0] mask;
  logic [31:0] buf_q, sum;
  logic [W-1:0] addr;
  logic err, start_ok, hs;
  assign start_ok = state == IDLE && i_start;
  assign hs = state == RECV && i_rx_valid;
  always_comb begin
    state_nx = state == IDLE  ? (!i_start ? IDLE : i_len == '0 ? DONE : i_len > CAP ? IDLE : RECV) :
               state == RECV  ? (hs && (cnt[1:0] == 2'd3 || cnt + (W+1)'(1) == len) ? WRITE : RECV) :
               state == WRITE ? (cnt == len ? DONE : RECV) :
               IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      mask  <= '0;
      buf_q <= '0;
      sum   <= '0;
      addr  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= start_ok && i_len > CAP;
      if (start_ok) begin
        len   <= i_len;
        cnt   <= '0;
        mask  <= '0;
        buf_q <= '0;
        sum   <= '0;
      end
      if (hs) begin
        buf_q[{cnt[1:0], 3'b000} +: 8] <= i_rx_data;
        mask[cnt[1:0]] <= 1'b1;
        cnt  <= cnt + (W+1)'(1);
        sum  <= sum + 32'(i_rx_data);
        addr <= {cnt[W-1:2], 2'b00};
      end
      if (state == WRITE) begin
        mask  <= '0;
        buf_q <= '0;
      end
    end
  end
  assign o_we       = state == WRITE;
  assign o_rx_ready = state == RECV;
  assign o_busy     = state != IDLE;
  assign o_done     = state == DONE;
  assign o_size     = o_we ? mask : '0;
  assign o_din      = o_we ? buf_q : '0;
  assign o_addr     = addr;
  assign o_err      = err;
  assign o_sum      = sum;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked against a word-packing reference model
module tb_imem_loader;
  localparam int AW = 12;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_rx_valid = 1'b0;
  logic [AW:0] i_len = '0;
  logic [7:0] i_rx_data = '0;
  logic o_rx_ready, o_we, o_busy, o_done, o_err;
  logic [AW-1:0] o_addr;
  logic [3:0] o_size;
  logic [31:0] o_din, o_sum;
  int n_vec = 0, n_err = 0, rdy_cnt = 0, err_cnt = 0;
  logic idle_bad = 1'b0;
  logic [7:0] img [$];
  logic [AW-1:0] wr_a [$];
  logic [3:0] wr_s [$];
  logic [31:0] wr_d [$];
  logic [7:0] mem [4096];

  imem_loader #(.DMEM_ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
    .o_addr(o_addr), .o_we(o_we), .o_size(o_size), .o_din(o_din),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_sum(o_sum)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_we) begin
      wr_a.push_back(o_addr);
      wr_s.push_back(o_size);
      wr_d.push_back(o_din);
      for (int k = 0; k < 4; k++)
        if (o_size[k]) mem[int'(o_addr) + k] <= o_din[8*k +: 8];
    end else if (o_size != 4'd0 || o_din != 32'd0) idle_bad <= 1'b1;
    if (o_rx_ready) rdy_cnt <= rdy_cnt + 1;
    if (o_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int len, input int mode);
    img.delete();
    for (int i = 0; i < len; i++)
      img.push_back(mode == 0 ? 8'(8'h11 * (i + 1)) : mode == 1 ? 8'(i) : 8'($urandom_range(255)));
  endtask

  task automatic run_load(input int len, input int stall_pct, input bit poke_start);
    int idx = 0, cyc = 0, nw;
    logic [31:0] es = '0;
    logic [31:0] d;
    logic [3:0] m;
    wr_a.delete(); wr_s.delete(); wr_d.delete();
    foreach (img[i]) es += 32'(img[i]);
    @(negedge i_clk);
    i_start = 1'b1;
    i_len = (AW+1)'(len);
    @(negedge i_clk);
    cyc = 1;
    i_start = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'(1));
    chk("ready_after_start", 64'(o_rx_ready), 64'(len > 0));
    while (!o_done && cyc < len * 4 + 50) begin
      if (idx < len) begin
        i_rx_valid = $urandom_range(99) >= stall_pct;
        i_rx_data = img[idx];
        if (i_rx_valid && o_rx_ready) idx++;
      end else i_rx_valid = 1'b0;
      i_start = poke_start ? 1'($urandom_range(1)) : 1'b0;
      @(negedge i_clk);
      cyc++;
    end
    i_rx_valid = 1'b0;
    i_start = 1'b0;
    chk("done_pulse", 64'(o_done), 64'(1));
    chk("bytes_taken", 64'(idx), 64'(len));
    if (stall_pct == 0) chk("latency", 64'(cyc), 64'(len + (len + 3) / 4 + 1));
    chk("sum", 64'(o_sum), 64'(es));
    nw = (len + 3) / 4;
    chk("write_count", 64'(wr_a.size()), 64'(nw));
    for (int w = 0; w < nw && w < wr_a.size(); w++) begin
      m = '0;
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < len) begin
          m[k] = 1'b1;
          d[8*k +: 8] = img[4*w + k];
        end
      chk("wr_addr", 64'(wr_a[w]), 64'(4 * w));
      chk("wr_size", 64'(wr_s[w]), 64'(m));
      chk("wr_data", 64'(wr_d[w]), 64'(d));
    end
    @(negedge i_clk);
    chk("idle_after_done", 64'({o_busy, o_done}), 64'(0));
    chk("sum_held", 64'(o_sum), 64'(es));
  endtask

  initial begin
    int r0, e0, n;
    #12;
    chk("reset_outputs", 64'({o_rx_ready, o_we, o_busy, o_done, o_err, o_size, o_addr}), 64'(0));
    chk("reset_data", 64'({o_din, o_sum}), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    fill(8, 0);
    run_load(8, 0, 1'b0);
    chk("full_w0", 64'(wr_d[0]), 64'(32'h44332211));
    chk("full_w1", 64'(wr_d[1]), 64'(32'h88776655));
    chk("full_sum", 64'(o_sum), 64'(32'h264));

    fill(6, 0);
    run_load(6, 0, 1'b0);
    chk("tail_w1", 64'({wr_a[1], wr_s[1], wr_d[1]}), 64'({12'h004, 4'b0011, 32'h00006655}));
    chk("tail_sum", 64'(o_sum), 64'(32'h165));

    r0 = rdy_cnt;
    fill(0, 0);
    run_load(0, 0, 1'b0);
    chk("len0_no_ready", 64'(rdy_cnt - r0), 64'(0));
    chk("len0_sum_cleared", 64'(o_sum), 64'(0));

    fill(5, 2);
    run_load(5, 0, 1'b0);
    e0 = err_cnt;
    @(negedge i_clk);
    i_start = 1'b1;
    i_len = 13'd4097;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("oversize_err", 64'({o_err, o_busy}), 64'(2'b10));
    chk("oversize_sum_cleared", 64'(o_sum), 64'(0));
    @(negedge i_clk);
    chk("oversize_err_pulse", 64'({o_err, o_busy}), 64'(0));
    chk("oversize_err_count", 64'(err_cnt - e0), 64'(1));

    fill(12, 2);
    run_load(12, 40, 1'b1);
    for (int t = 0; t < 4; t++) begin
      fill($urandom_range(1, 40), 2);
      run_load(img.size(), $urandom_range(0, 60), 1'b1);
    end

    fill(8, 2);
    wr_a.delete(); wr_s.delete(); wr_d.delete();
    @(negedge i_clk);
    i_start = 1'b1;
    i_len = 13'd8;
    @(negedge i_clk);
    i_start = 1'b0;
    n = 0;
    for (int g = 0; g < 20 && n < 3; g++) begin
      i_rx_valid = 1'b1;
      i_rx_data = img[n];
      if (o_rx_ready) n++;
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    chk("pre_reset_busy", 64'(o_busy), 64'(1));
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", 64'({o_rx_ready, o_we, o_busy, o_done, o_err, o_size, o_addr}), 64'(0));
    chk("rst_async_data", 64'({o_din, o_sum}), 64'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("rst_no_resume", 64'(o_busy), 64'(0));
    chk("rst_no_write", 64'(wr_a.size()), 64'(0));
    img = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(4, 0, 1'b0);
    chk("deadbeef", 64'({wr_a[0], wr_s[0], wr_d[0]}), 64'({12'h000, 4'b1111, 32'hDEADBEEF}));

    fill(4096, 1);
    run_load(4096, 0, 1'b0);
    chk("cap_last_addr", 64'(wr_a[wr_a.size() - 1]), 64'(12'hFFC));
    for (int w = 0; w < 1024; w++)
      chk("cap_mem", 64'({mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]}),
          64'({img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]}));

    chk("idle_lanes_zero", 64'(idle_bad), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
